ysyx_25020047_lsu: RTL and testbench
====================================

# ysyx_25020047_lsu

Load/store unit between the execute stage and the write-back unit. It accepts one memory operation at a time from EXU and converts it into a word-aligned request on the data-memory bus. It returns the extracted, sign/zero-extended load data to WBU as `memdata`. Non-memory instructions pass through with `memdata = 0` so WBU sees one uniform handshake.

## Interface
Parameters:
- `RSP_TIMEOUT`, 255: cycles spent in WAIT without `mem_rsp_valid` before the operation is aborted with `out_err`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `in_valid` / `in_ready`  in / out  1  upstream handshake. Transfer when both are high.
- `in_load`, `in_store`  in  1  operation kind. Both low means non-memory instruction.
- `in_size`  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `in_unsigned`  in  1  zero-extend the load (lbu/lhu).
- `in_addr`  in  32  effective byte address.
- `in_wdata`  in  32  store data in the low bits.
- `out_valid` / `out_ready`  out / in  1  downstream handshake to WBU.
- `out_memdata`  out  32  extended load data; 0 for stores, non-memory instructions and errors.
- `out_err`  out  1  timeout or misaligned-trap indication, qualified by `out_valid`.
- `mem_req_valid` / `mem_req_ready`  out / in  1  request handshake.
- `mem_req_addr`  out  32  equal to `{in_addr[31:2], 2'b00}`.
- `mem_req_wen`  out  1  high for stores.
- `mem_req_wdata`  out  32  lane-replicated store data.
- `mem_req_wmask`  out  4  byte enables; 0 for loads.
- `mem_rsp_valid`  in  1  response or write acknowledgement. No ready; the LSU always sinks it while in WAIT.
- `mem_rsp_rdata`  in  32  read word.

## Operation
States:
- **IDLE**
  - `in_ready = 1`; all other outputs are inactive.
  - On transfer, latch all `in_*` fields.
  - Non-memory instruction → RESP, with `memdata = 0`, `err = 0`.
  - Otherwise → REQ.
  - Load and store both high: treated as a load.
- **REQ**
  - `mem_req_valid = 1`; request fields are driven from the latched operation.
  - On `mem_req_ready` → WAIT, with the timeout counter cleared.
- **WAIT**
  - On `mem_rsp_valid`, capture the extracted data (0 for a store) → RESP.
  - Otherwise the counter increments. When it reaches `RSP_TIMEOUT` → RESP, with `err = 1`, `memdata = 0`.
- **RESP**
  - `out_valid = 1`; `out_memdata` and `out_err` are held stable.
  - On `out_ready` → IDLE.

Lane rules, with `L = addr[1:0]`:
- Loads:
  - Byte: take `rdata[8L+7:8L]`.
  - Half: take `rdata[16·addr[1]+15 : 16·addr[1]]`.
  - Word: the whole word.
  - Sign-extend from bit 7 or bit 15 unless `in_unsigned` is set.
- Stores:
  - Byte: wdata = `{4{b}}`, wmask = `0001 << L`.
  - Half: wdata = `{2{h}}`, wmask = `0011 << (2·addr[1])`.
  - Word: wmask = `1111`.
- Misaligned cases (half with `addr[0]=1`, word with `L≠0`) follow Configuration.
- `mem_rsp_valid` outside WAIT is ignored.

## Timing
- Reset values: state IDLE, so `in_ready = 1`. `out_valid`, `out_err`, `mem_req_valid`, `mem_req_wen` are 0. `out_memdata`, `mem_req_addr`, `mem_req_wdata`, `mem_req_wmask` are 0.
- Reset asserted mid-operation forces IDLE immediately. Any outstanding bus transaction is abandoned and `mem_req_valid` drops in the same cycle.
- Non-memory instruction: `out_valid` is high in the cycle after acceptance.
- Memory operation, best case:
  - Accept at edge N.
  - `mem_req_valid` is high in cycle N+1.
  - With `mem_req_ready` at N+1 and `mem_rsp_valid` in the first WAIT cycle (N+2), `out_valid` is high in cycle N+3.
- `mem_req_valid` and its fields stay stable until `mem_req_ready`.
- `out_*` stay stable until `out_ready`.
- Back-to-back: the next `in_ready` comes the cycle after the RESP handshake. There is no overlap of operations.

## Configuration
- `YSYX_25020047_LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access issues no bus request.
  - IDLE → RESP with `out_err = 1`, `out_memdata = 0`.
- Not defined:
  - The low address bits are truncated: half uses `addr[1]`, word uses lane 0.
  - The access is issued normally and `out_err` is driven only by timeout.

## Structure
- Package `ysyx_25020047_pkg`:
  - State enum (IDLE/REQ/WAIT/RESP).
  - Size encodings `SZ_B/SZ_H/SZ_W`.
  - Default timeout constant.
- Sub-module `ysyx_25020047_lsu_align`, combinational:
  - Load lane extraction plus sign/zero extension.
  - Store wdata replication and wmask generation.
  - Misalignment detect.
- The top level keeps only the FSM, latches and the timeout counter.

## Test plan
- Load byte signed at `addr=0x80000003`, `rdata=0x80FF1234` → `mem_req_addr=0x80000000`, `wmask=0`, `out_memdata=0xFFFFFF80`. The unsigned variant gives `0x00000080`.
- Store half at `addr=0x80000102`, `wdata=0x0000ABCD` → `mem_req_wdata=0xABCDABCD`, `wmask=0b1100`, `wen=1`. After the ack: `out_memdata=0`, `out_err=0`.
- Non-memory instruction with `out_ready=1` → `out_valid` high one cycle after acceptance, `out_memdata=0`, no `mem_req_valid` pulse.
- `mem_req_ready` held low 5 cycles, then the response arrives 3 cycles after the grant → request fields stable throughout; `out_valid` in the cycle after `mem_rsp_valid`. `out_ready` held low 4 cycles → outputs stable and `in_ready=0`.
- Timeout with `RSP_TIMEOUT=4` and no response → `out_valid` with `out_err=1`, `out_memdata=0`. A response arriving afterwards in IDLE is ignored.
- Misaligned word load at `addr=0x80000002` → with the macro, `out_err=1` and no bus request. Without the macro, `mem_req_addr=0x80000000` and `out_memdata` equals the full `rdata`. Async `rst` pulsed during WAIT → all outputs return to their reset values within the same cycle.

Source files
------------

// File: rtl/ysyx_25020047_pkg.sv
// rtl/ysyx_25020047_pkg.sv - shared state, size encodings and defaults for the LSU
package ysyx_25020047_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam int LSU_RSP_TIMEOUT_DEF = 255;

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// rtl/ysyx_25020047_lsu_align.sv - load lane extraction/extension, store replication/mask, misalign detect
module ysyx_25020047_lsu_align
   import ysyx_25020047_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_ld_data,
   output logic [31:0] o_st_wdata,
   output logic [3:0]  o_st_wmask,
   output logic        o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed lane from the read word and extend it to 32 bits.
   always_comb begin
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      // Half lanes ignore addr[0]; a misaligned half is truncated to its aligned pair.
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_size)
         SZ_B:    o_ld_data = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         SZ_H:    o_ld_data = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         default: o_ld_data = i_rdata;
      endcase
   end

   // Replicate store data across all lanes so the byte enables alone select the target.
   always_comb begin
      case (i_size)
         SZ_B: begin
            o_st_wdata = {4{i_wdata[7:0]}};
            o_st_wmask = 4'b0001 << i_addr_lo;
         end
         SZ_H: begin
            o_st_wdata = {2{i_wdata[15:0]}};
            o_st_wmask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            o_st_wdata = i_wdata;
            o_st_wmask = 4'b1111;
         end
      endcase
   end

   // Reserved size 11 behaves as a word, so any set size[1] needs lane 0.
   assign o_misalign = (i_size == SZ_H) ? i_addr_lo[0] : (i_size[1] & (i_addr_lo != 2'b00));

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// rtl/ysyx_25020047_lsu.sv - load/store unit FSM; define YSYX_25020047_LSU_MISALIGN_TRAP_EN to trap misaligned accesses
module ysyx_25020047_lsu
   import ysyx_25020047_pkg::*;
#(
   parameter int RSP_TIMEOUT = LSU_RSP_TIMEOUT_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_memdata,
   output logic        out_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wmask,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata
);

`ifdef YSYX_25020047_LSU_MISALIGN_TRAP_EN
   localparam logic MIS_TRAP = 1'b1;
`else
   localparam logic MIS_TRAP = 1'b0;
`endif

   lsu_state_t  r_state, w_next;
   logic        r_store, r_unsigned, r_err;
   logic [1:0]  r_size;
   logic [31:0] r_addr, r_wdata, r_memdata, r_cnt;

   logic        w_in_mem, w_trap, w_timeout, w_misalign;
   logic [1:0]  w_size, w_addr_lo;
   logic [31:0] w_ld_data, w_st_wdata;
   logic [3:0]  w_st_wmask;

   // In IDLE the aligner looks at the incoming op so a misaligned access can be refused before latching.
   assign w_size    = (r_state == IDLE) ? in_size : r_size;
   assign w_addr_lo = (r_state == IDLE) ? in_addr[1:0] : r_addr[1:0];
   assign w_in_mem  = in_load | in_store;
   assign w_trap    = MIS_TRAP & w_in_mem & w_misalign;
   assign w_timeout = (r_cnt == 32'(RSP_TIMEOUT - 1));

   ysyx_25020047_lsu_align u_align (
      .i_size     (w_size),
      .i_unsigned (r_unsigned),
      .i_addr_lo  (w_addr_lo),
      .i_wdata    (r_wdata),
      .i_rdata    (mem_rsp_rdata),
      .o_ld_data  (w_ld_data),
      .o_st_wdata (w_st_wdata),
      .o_st_wmask (w_st_wmask),
      .o_misalign (w_misalign)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic: one operation in flight, no overlap.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_next = (!w_in_mem || w_trap) ? RESP : REQ;
         REQ:     if (mem_req_ready) w_next = WAIT;
         WAIT:    if (mem_rsp_valid || w_timeout) w_next = RESP;
         RESP:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs decode purely from state so reset clears them in the same cycle.
   always_comb begin
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      out_memdata   = 32'h0;
      out_err       = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = 32'h0;
      mem_req_wen   = 1'b0;
      mem_req_wdata = 32'h0;
      mem_req_wmask = 4'h0;
      case (r_state)
         IDLE: in_ready = 1'b1;
         REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {r_addr[31:2], 2'b00};
            mem_req_wen   = r_store;
            mem_req_wdata = r_store ? w_st_wdata : 32'h0;
            mem_req_wmask = r_store ? w_st_wmask : 4'h0;
         end
         RESP: begin
            out_valid   = 1'b1;
            out_memdata = r_memdata;
            out_err     = r_err;
         end
         default: ;
      endcase
   end

   // Operation latches, result capture and the response timeout counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_store    <= 1'b0;
         r_unsigned <= 1'b0;
         r_size     <= SZ_B;
         r_addr     <= 32'h0;
         r_wdata    <= 32'h0;
         r_memdata  <= 32'h0;
         r_err      <= 1'b0;
         r_cnt      <= 32'h0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               // Load and store both set resolves to a load.
               r_store    <= in_store & ~in_load;
               r_unsigned <= in_unsigned;
               r_size     <= in_size;
               r_addr     <= in_addr;
               r_wdata    <= in_wdata;
               r_memdata  <= 32'h0;
               r_err      <= w_trap;
            end
            REQ: r_cnt <= 32'h0;
            WAIT: begin
               if (mem_rsp_valid) begin
                  r_memdata <= r_store ? 32'h0 : w_ld_data;
                  r_err     <= 1'b0;
               end else if (w_timeout) begin
                  r_memdata <= 32'h0;
                  r_err     <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 32'h1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// tb/tb_ysyx_25020047_lsu.sv - self-checking bench for ysyx_25020047_lsu
`timescale 1ns/1ps
module tb_ysyx_25020047_lsu;

   localparam int T = 4;
`ifdef YSYX_25020047_LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_load = 1'b0, in_store = 1'b0, in_unsigned = 1'b0;
   logic [1:0]  in_size = 2'b00;
   logic [31:0] in_addr = 32'h0, in_wdata = 32'h0;
   logic        out_ready = 1'b0, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_rdata = 32'h0;
   logic        in_ready, out_valid, out_err, mem_req_valid, mem_req_wen;
   logic [31:0] out_memdata, mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wmask;

   always #5 clk = ~clk;

   ysyx_25020047_lsu #(.RSP_TIMEOUT(T)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
      .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_memdata(out_memdata), .out_err(out_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
   );

   int n_checks = 0, n_fail = 0;
   // 0 idle, 1 request expected, 2 waiting for response, 3 result expected
   int phase = 0;
   logic [31:0] e_addr = 0, e_wdata = 0, e_memdata = 0;
   logic [3:0]  e_wmask = 0;
   logic        e_wen = 0, e_err = 0;
   logic [31:0] cap_addr = 0, cap_wdata = 0, cap_memdata = 0;
   logic [3:0]  cap_wmask = 0;
   logic        cap_wen = 0, cap_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rules written as plain arithmetic on the byte address.
   function automatic logic [31:0] m_load(input int sz, input bit uns, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v;
      if (sz == 0) begin
         v = (rd >> (8 * (a % 4))) & 32'hFF;
         if (!uns && v >= 32'h80) v = v - 32'h100;
      end else if (sz == 1) begin
         v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (!uns && v >= 32'h8000) v = v - 32'h10000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] wd);
      if (sz == 0) return (wd & 32'hFF) * 32'h01010101;
      if (sz == 1) return (wd & 32'hFFFF) * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [3:0] m_wmask(input int sz, input logic [31:0] a);
      if (sz == 0) return 4'(1 << (a % 4));
      if (sz == 1) return 4'(3 << (2 * ((a / 2) % 2)));
      return 4'hF;
   endfunction

   function automatic bit m_mis(input int sz, input logic [31:0] a);
      if (sz == 1) return (a % 2) != 0;
      if (sz >= 2) return (a % 4) != 0;
      return 1'b0;
   endfunction

   // Compare process: every cycle, outputs against the phase-level expectation.
   always @(negedge clk) begin
      chk("in_ready", 32'(in_ready), 32'(phase == 0));
      chk("mem_req_valid", 32'(mem_req_valid), 32'(phase == 1));
      chk("out_valid", 32'(out_valid), 32'(phase == 3));
      if (phase == 1) begin
         chk("req_addr", mem_req_addr, e_addr);
         chk("req_wen", 32'(mem_req_wen), 32'(e_wen));
         chk("req_wmask", 32'(mem_req_wmask), 32'(e_wmask));
         if (e_wen) chk("req_wdata", mem_req_wdata, e_wdata);
         cap_addr = mem_req_addr; cap_wdata = mem_req_wdata;
         cap_wmask = mem_req_wmask; cap_wen = mem_req_wen;
      end
      if (phase == 3) begin
         chk("out_memdata", out_memdata, e_memdata);
         chk("out_err", 32'(out_err), 32'(e_err));
         cap_memdata = out_memdata; cap_err = out_err;
      end
      if (phase == 0) begin
         chk("idle_req_addr", mem_req_addr, 32'h0);
         chk("idle_req_wmask", 32'(mem_req_wmask), 32'h0);
         chk("idle_memdata", out_memdata, 32'h0);
         chk("idle_err", 32'(out_err), 32'h0);
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b0;
         mem_rsp_valid = 1'($urandom);
         mem_rsp_rdata = $urandom;
         step();
      end
      mem_rsp_valid = 1'b0;
   endtask

   // Drives one operation and plays the memory; called at posedge+1 with the DUT idle.
   task automatic do_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int gd, input int rdly, input int od);
      bit mem, is_st, trap, tmo;
      int szi;
      mem   = ld || st;
      is_st = st && !ld;
      szi   = int'(sz);
      trap  = TRAP && mem && m_mis(szi, a);
      tmo   = mem && !trap && (rdly >= T);
      e_addr    = a & ~32'h3;
      e_wen     = is_st;
      e_wdata   = m_wdata(szi, wd);
      e_wmask   = is_st ? m_wmask(szi, a) : 4'h0;
      e_err     = trap || tmo;
      e_memdata = (!mem || is_st || trap || tmo) ? 32'h0 : m_load(szi, uns, a, rd);
      in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz;
      in_unsigned = uns; in_addr = a; in_wdata = wd;
      step();
      in_valid = 1'b0; in_load = 1'($urandom); in_store = 1'($urandom);
      in_size = 2'($urandom); in_addr = $urandom; in_wdata = $urandom;
      if (mem && !trap) begin
         phase = 1;
         for (int i = 0; i < gd; i++) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'($urandom);
            mem_rsp_rdata = $urandom;
            step();
         end
         mem_rsp_valid = 1'b0;
         mem_req_ready = 1'b1;
         step();
         mem_req_ready = 1'b0;
         phase = 2;
         if (!tmo) begin
            for (int i = 0; i < rdly; i++) begin
               mem_rsp_rdata = $urandom;
               step();
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rd;
            step();
            mem_rsp_valid = 1'b0;
         end else begin
            for (int i = 0; i < T; i++) begin
               mem_rsp_rdata = $urandom;
               step();
            end
         end
      end
      phase = 3;
      for (int i = 0; i < od; i++) begin
         out_ready = 1'b0;
         mem_rsp_valid = 1'($urandom);
         mem_rsp_rdata = $urandom;
         step();
      end
      mem_rsp_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      phase = 0;
   endtask

   // Start an op and assert reset mid-cycle once the given phase is reached.
   task automatic rst_mid(input int at_phase);
      in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'b10;
      in_addr = 32'h80000040; in_wdata = 32'h0;
      e_addr = 32'h80000040; e_wen = 1'b0; e_wmask = 4'h0;
      step();
      in_valid = 1'b0;
      phase = 1;
      if (at_phase == 2) begin
         mem_req_ready = 1'b1;
         step();
         mem_req_ready = 1'b0;
         phase = 2;
      end
      #1 rst = 1'b1; phase = 0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_req_addr", mem_req_addr, 32'h0);
      chk("rst_wen", 32'(mem_req_wen), 32'h0);
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      step();
      step();
      rst = 1'b0;
      step();

      do_op(1, 0, 2'b00, 0, 32'h80000003, 32'h0, 32'h80FF1234, 0, 0, 0);
      chk("lb_addr", cap_addr, 32'h80000000);
      chk("lb_wmask", 32'(cap_wmask), 32'h0);
      chk("lb_data", cap_memdata, 32'hFFFFFF80);
      do_op(1, 0, 2'b00, 1, 32'h80000003, 32'h0, 32'h80FF1234, 0, 0, 0);
      chk("lbu_data", cap_memdata, 32'h00000080);

      do_op(0, 1, 2'b01, 0, 32'h80000102, 32'h0000ABCD, 32'h11111111, 0, 0, 0);
      chk("sh_wdata", cap_wdata, 32'hABCDABCD);
      chk("sh_wmask", 32'(cap_wmask), 32'hC);
      chk("sh_wen", 32'(cap_wen), 32'h1);
      chk("sh_data", cap_memdata, 32'h0);
      chk("sh_err", 32'(cap_err), 32'h0);

      cap_memdata = 32'hDEADBEEF;
      do_op(0, 0, 2'b10, 0, 32'h12345678, 32'h55, 32'h0, 0, 0, 0);
      chk("nonmem_data", cap_memdata, 32'h0);

      do_op(1, 0, 2'b10, 0, 32'h80000010, 32'h0, 32'h12345678, 5, 2, 4);
      chk("slow_data", cap_memdata, 32'h12345678);

      do_op(1, 0, 2'b10, 0, 32'h80000020, 32'h0, 32'hA5A5A5A5, 0, T, 1);
      chk("tmo_err", 32'(cap_err), 32'h1);
      chk("tmo_data", cap_memdata, 32'h0);
      idle(3);

      cap_addr = 32'h0;
      do_op(1, 0, 2'b10, 0, 32'h80000002, 32'h0, 32'hCAFEF00D, 0, 0, 0);
      chk("mis_err", 32'(cap_err), TRAP ? 32'h1 : 32'h0);
      chk("mis_addr", cap_addr, TRAP ? 32'h0 : 32'h80000000);
      chk("mis_data", cap_memdata, TRAP ? 32'h0 : 32'hCAFEF00D);

      rst_mid(2);
      rst_mid(1);

      for (int n = 0; n < 120; n++) begin
         int kind;
         kind = $urandom_range(0, 3);
         idle($urandom_range(0, 2));
         do_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 2'($urandom), 1'($urandom),
               32'h80000000 | ($urandom & 32'hFFFF), $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2));
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
